// File: rtl/fir_out_checker.sv
// Compares DUT samples against a FIFO-buffered golden stream within +/-TOL and reports sticky errors, counters and a final verdict.
// All outputs are registered one cycle after the sampled inputs; there is no backpressure, and golden samples arriving at a full FIFO are dropped and flagged.
module fir_out_checker #(
  parameter int NB       = 11,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16,
  parameter int TOL      = 0,
  parameter int DRAIN_TO = 64
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             VIN,
  input  logic [NB-1:0]    DIN,
  input  logic             EXP_VIN,
  input  logic [NB-1:0]    EXP_DIN,
  input  logic             END_SIM,
  output logic             MISMATCH,
  output logic             ERR,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] SAMPLE_CNT,
  output logic             DONE,
  output logic             PASS
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(DRAIN_TO + 1);
  localparam logic signed [NB:0] TOL_P = (NB+1)'(TOL);
  localparam logic signed [NB:0] TOL_N = -TOL_P;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [NB-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ, occ_nxt;
  logic [TW-1:0]   timer;

  logic            active, empty, full;
  logic            bypass, push, pop, ovf_ev, unf_ev, mis_ev, in_tol;
  logic            drain_empty, timeout, err_nxt;
  logic [NB-1:0]   exp_val;
  logic signed [NB:0] din_x, exp_x, diff;
  logic [CNT_W:0]  err_add, err_sum;

  always_comb begin
    active  = (state != S_DONE);
    empty   = (occ == '0);
    full    = (occ == (AW+1)'(DEPTH));
    bypass  = active & VIN & empty & EXP_VIN;
    pop     = active & VIN & ~empty;
    // A full FIFO can still accept a push when the same cycle pops the head.
    push    = active & EXP_VIN & ~bypass & (~full | VIN);
    ovf_ev  = active & EXP_VIN & full & ~VIN;
    unf_ev  = active & VIN & empty & ~EXP_VIN;
    exp_val = empty ? EXP_DIN : mem[rd_ptr];
    // One extra bit keeps full-scale differences from wrapping into the tolerance window.
    din_x   = {DIN[NB-1], DIN};
    exp_x   = {exp_val[NB-1], exp_val};
    diff    = din_x - exp_x;
    in_tol  = (diff >= TOL_N) && (diff <= TOL_P);
    mis_ev  = active & VIN & (unf_ev | ~in_tol);
    occ_nxt = occ + (AW+1)'(push) - (AW+1)'(pop);
    drain_empty = (state == S_DRAIN) && (occ_nxt == '0);
    timeout     = (state == S_DRAIN) && !drain_empty && (timer <= TW'(1));
    err_add = (CNT_W+1)'(mis_ev) + (timeout ? (CNT_W+1)'(occ_nxt) : '0);
    err_sum = {1'b0, ERR_CNT} + err_add;
    err_nxt = ERR | mis_ev | ovf_ev | timeout;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= EXP_DIN;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      timer      <= '0;
      MISMATCH   <= 1'b0;
      ERR        <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
      ERR_CNT    <= '0;
      SAMPLE_CNT <= '0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ        <= occ_nxt;
      MISMATCH   <= mis_ev;
      ERR        <= err_nxt;
      OVERFLOW   <= OVERFLOW | ovf_ev;
      UNDERFLOW  <= UNDERFLOW | unf_ev;
      ERR_CNT    <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      if (active && VIN && (SAMPLE_CNT != '1))
        SAMPLE_CNT <= SAMPLE_CNT + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (END_SIM) begin
            state <= S_DRAIN;
            timer <= TW'(DRAIN_TO);
          end else if (VIN || EXP_VIN) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (END_SIM) begin
            state <= S_DRAIN;
            timer <= TW'(DRAIN_TO);
          end
        end
        S_DRAIN: begin
          if (drain_empty || timeout) begin
            state <= S_DONE;
            DONE  <= 1'b1;
            PASS  <= ~err_nxt;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
